// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, feeder state encoding and index helpers for the 8-point FFT load path.
`default_nettype none

package fft_pkg;

   localparam int FFT_N     = 8;
   localparam int FFT_LOG2N = 3;

   typedef enum logic [1:0] {
      ST_FILL      = 2'd0,
      ST_START     = 2'd1,
      ST_SEND      = 2'd2,
      ST_WAIT_DONE = 2'd3
   } feeder_state_t;

   // Decimation-in-time input order for a 3-bit index.
   function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] k);
      return {k[0], k[1], k[2]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sample_buf.sv
// fft_sample_buf: one-frame complex sample store, single write port, asynchronous read port, data not reset.
`default_nettype none

module fft_sample_buf #(
   parameter int DW    = 32,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [2*DW-1:0] wr_data,
   input  logic [AW-1:0]   rd_addr,
   output logic [2*DW-1:0] rd_data
);

   logic [2*DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fft_sample_feeder.sv
// fft_sample_feeder: buffers one 8-sample frame and streams it into the FFT core after a start pulse.
// Build option FFT_FEEDER_BITREV_EN: send the frame in bit-reversed (DIT) order instead of natural order.
`default_nettype none

module fft_sample_feeder
   import fft_pkg::*;
#(
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_s_valid,
   output logic          o_s_ready,
   input  logic [DW-1:0] i_s_re,
   input  logic [DW-1:0] i_s_im,
   output logic          o_start,
   output logic          o_valid_in,
   output logic [DW-1:0] o_re,
   output logic [DW-1:0] o_im,
   output logic [2:0]    o_idx,
   input  logic          i_done,
   output logic          o_busy,
   output logic [15:0]   o_frame_cnt,
   output logic          o_timeout_err,
   input  logic          i_clr_err
);

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   feeder_state_t state, state_nxt;

   logic [FFT_LOG2N-1:0] wr_cnt;
   logic [FFT_LOG2N-1:0] rd_cnt;
   logic [15:0]          timer;
   logic [15:0]          frame_cnt;
   logic                 timeout_err;

   logic                 accept;
   logic                 timer_hit;
   logic [FFT_LOG2N-1:0] send_idx;
   logic [2*DW-1:0]      rd_data;

   assign accept    = (state == ST_FILL) && i_s_valid;
   assign timer_hit = (timer == TIMER_LAST);

`ifdef FFT_FEEDER_BITREV_EN
   assign send_idx = bitrev3(rd_cnt);
`else
   assign send_idx = rd_cnt;
`endif

   fft_sample_buf #(
      .DW    (DW),
      .DEPTH (FFT_N),
      .AW    (FFT_LOG2N)
   ) u_buf (
      .clk     (i_clk),
      .wr_en   (accept),
      .wr_addr (wr_cnt),
      .wr_data ({i_s_re, i_s_im}),
      .rd_addr (send_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FILL: begin
            if (accept && (wr_cnt == 3'd7)) begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (rd_cnt == 3'd7) begin
               state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (i_done || timer_hit) begin
               state_nxt = ST_FILL;
            end
         end
         default: begin
            state_nxt = ST_FILL;
         end
      endcase
   end

   // wr_cnt wraps 7->0 on the last handshake, so it is already 0 for the next frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         timer  <= '0;
      end else begin
         if (accept) begin
            wr_cnt <= wr_cnt + 3'd1;
         end
         if (state == ST_START) begin
            rd_cnt <= '0;
         end else if (state == ST_SEND) begin
            rd_cnt <= rd_cnt + 3'd1;
         end
         if (state == ST_SEND) begin
            timer <= '0;
         end else if (state == ST_WAIT_DONE) begin
            timer <= timer + 16'd1;
         end
      end
   end

   // A done pulse that coincides with the last timer cycle counts as success.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frame_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         if ((state == ST_WAIT_DONE) && i_done) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (i_clr_err) begin
            timeout_err <= 1'b0;
         end else if ((state == ST_WAIT_DONE) && !i_done && timer_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

   always_comb begin
      o_s_ready     = (state == ST_FILL);
      o_start       = (state == ST_START);
      o_valid_in    = (state == ST_SEND);
      o_busy        = (state != ST_FILL);
      o_frame_cnt   = frame_cnt;
      o_timeout_err = timeout_err;
      o_idx         = '0;
      o_re          = '0;
      o_im          = '0;
      if (state == ST_SEND) begin
         o_idx = send_idx;
         o_re  = rd_data[2*DW-1:DW];
         o_im  = rd_data[DW-1:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft_sample_feeder.sv
// tb_fft_sample_feeder: randomized frames checked against a transaction-level model of the feeder.
`default_nettype none

module tb_fft_sample_feeder;

   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_s_valid;
   logic          o_s_ready;
   logic [DW-1:0] i_s_re;
   logic [DW-1:0] i_s_im;
   logic          o_start;
   logic          o_valid_in;
   logic [DW-1:0] o_re;
   logic [DW-1:0] o_im;
   logic [2:0]    o_idx;
   logic          i_done;
   logic          o_busy;
   logic [15:0]   o_frame_cnt;
   logic          o_timeout_err;
   logic          i_clr_err;

   fft_sample_feeder #(
      .DW      (DW),
      .TIMEOUT (TMO)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_s_valid     (i_s_valid),
      .o_s_ready     (o_s_ready),
      .i_s_re        (i_s_re),
      .i_s_im        (i_s_im),
      .o_start       (o_start),
      .o_valid_in    (o_valid_in),
      .o_re          (o_re),
      .o_im          (o_im),
      .o_idx         (o_idx),
      .i_done        (i_done),
      .o_busy        (o_busy),
      .o_frame_cnt   (o_frame_cnt),
      .o_timeout_err (o_timeout_err),
      .i_clr_err     (i_clr_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the frame last accepted, frames completed, sticky error.
   logic [31:0] cur_re [8];
   logic [31:0] cur_im [8];
   logic [31:0] nxt_re [8];
   logic [31:0] nxt_im [8];
   logic [15:0] exp_frames;
   logic        exp_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int send_pos(input int k);
`ifdef FFT_FEEDER_BITREV_EN
      return (k % 2) * 4 + ((k / 2) % 2) * 2 + (k / 4);
`else
      return k;
`endif
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic new_next_frame();
      for (int i = 0; i < 8; i++) begin
         nxt_re[i] = $urandom;
         nxt_im[i] = $urandom;
      end
   endtask

   task automatic take_next_frame();
      for (int i = 0; i < 8; i++) begin
         cur_re[i] = nxt_re[i];
         cur_im[i] = nxt_im[i];
      end
   endtask

   // Offers the eight samples of cur_* with random idle gaps; ends in the cycle after the last handshake.
   task automatic fill_frame(input int gap_pct, input bit stray_done);
      for (int i = 0; i < 8; i++) begin
         int gaps = 0;
         while (gaps < 4 && $urandom_range(0, 99) < gap_pct) begin
            i_s_valid = 1'b0;
            i_done    = stray_done ? 1'($urandom_range(0, 1)) : 1'b0;
            check("fill_ready", o_s_ready, 1);
            step();
            gaps++;
         end
         i_s_valid = 1'b1;
         i_s_re    = cur_re[i];
         i_s_im    = cur_im[i];
         i_done    = stray_done ? 1'($urandom_range(0, 1)) : 1'b0;
         check("fill_ready", o_s_ready, 1);
         check("fill_no_start", o_start, 0);
         check("fill_frame_cnt", o_frame_cnt, exp_frames);
         step();
      end
      i_done    = 1'b0;
      i_s_valid = 1'b0;
   endtask

   // Start cycle plus eight send cycles; abort_at in 0..7 pulls reset in that send cycle.
   task automatic send_frame(input bit hold, input bit stray_done, input int abort_at);
      i_s_valid = hold;
      i_s_re    = nxt_re[0];
      i_s_im    = nxt_im[0];
      i_done    = stray_done ? 1'($urandom_range(0, 1)) : 1'b0;
      check("start_pulse", o_start, 1);
      check("start_ready", o_s_ready, 0);
      check("start_valid", o_valid_in, 0);
      check("start_busy", o_busy, 1);
      for (int k = 0; k < 8; k++) begin
         step();
         i_done = stray_done ? 1'($urandom_range(0, 1)) : 1'b0;
         if (k == abort_at) begin
            i_rst_n = 1'b0;
            #1;
            check("rst_valid", o_valid_in, 0);
            check("rst_ready", o_s_ready, 1);
            check("rst_frame_cnt", o_frame_cnt, 0);
            check("rst_busy", o_busy, 0);
            check("rst_idx", o_idx, 0);
            step();
            i_rst_n    = 1'b1;
            i_s_valid  = 1'b0;
            i_done     = 1'b0;
            exp_frames = '0;
            exp_err    = 1'b0;
            return;
         end
         check("send_valid", o_valid_in, 1);
         check("send_no_start", o_start, 0);
         check("send_ready", o_s_ready, 0);
         check("send_idx", o_idx, send_pos(k));
         check("send_re", o_re, cur_re[send_pos(k)]);
         check("send_im", o_im, cur_im[send_pos(k)]);
      end
      step();
   endtask

   // done_at/clr_at name the wait cycle (0-based) carrying the pulse; TMO or more means never.
   task automatic wait_done(input int done_at, input int clr_at);
      bit got_done = 1'b0;
      for (int j = 0; j < TMO; j++) begin
         i_done    = (j == done_at);
         i_clr_err = (j == clr_at);
         check("wait_valid", o_valid_in, 0);
         check("wait_ready", o_s_ready, 0);
         check("wait_busy", o_busy, 1);
         check("wait_re_zero", o_re, 0);
         check("wait_err", o_timeout_err, exp_err);
         step();
         if (j == clr_at) exp_err = 1'b0;
         if (j == done_at) begin
            got_done = 1'b1;
            break;
         end
      end
      i_done    = 1'b0;
      i_clr_err = 1'b0;
      if (got_done) exp_frames = exp_frames + 16'd1;
      else if (clr_at != TMO - 1) exp_err = 1'b1;
      check("idle_ready", o_s_ready, 1);
      check("idle_busy", o_busy, 0);
      check("idle_frame_cnt", o_frame_cnt, exp_frames);
      check("idle_err", o_timeout_err, exp_err);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: observed no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] floats [8];
      floats[0] = 32'h3F800000; floats[1] = 32'h40000000;
      floats[2] = 32'h40400000; floats[3] = 32'h40800000;
      floats[4] = 32'h40A00000; floats[5] = 32'h40C00000;
      floats[6] = 32'h40E00000; floats[7] = 32'h41000000;

      i_rst_n = 1'b0; i_s_valid = 1'b0; i_s_re = '0; i_s_im = '0;
      i_done = 1'b0; i_clr_err = 1'b0;
      exp_frames = '0; exp_err = 1'b0;
      step(); step();
      check("reset_ready", o_s_ready, 1);
      check("reset_start", o_start, 0);
      check("reset_valid", o_valid_in, 0);
      check("reset_busy", o_busy, 0);
      check("reset_frame_cnt", o_frame_cnt, 0);
      check("reset_err", o_timeout_err, 0);
      check("reset_idx", o_idx, 0);
      i_rst_n = 1'b1;
      step();

      // Known float ramp 1.0..8.0, no gaps.
      for (int i = 0; i < 8; i++) begin
         cur_re[i] = floats[i];
         cur_im[i] = '0;
      end
      new_next_frame();
      fill_frame(0, 1'b0);
      send_frame(1'b0, 1'b0, -1);
      wait_done(3, -1);

      // Done on the last timer cycle beats the timeout.
      new_next_frame(); take_next_frame(); new_next_frame();
      fill_frame(30, 1'b0);
      send_frame(1'b0, 1'b0, -1);
      wait_done(TMO - 1, -1);

      // Pure timeout, then explicit clear.
      new_next_frame(); take_next_frame(); new_next_frame();
      fill_frame(30, 1'b0);
      send_frame(1'b0, 1'b0, -1);
      wait_done(TMO, -1);
      i_clr_err = 1'b1;
      step();
      i_clr_err = 1'b0;
      exp_err   = 1'b0;
      check("clr_err", o_timeout_err, 0);

      // Clear in the same cycle as the timeout wins.
      new_next_frame(); take_next_frame(); new_next_frame();
      fill_frame(20, 1'b0);
      send_frame(1'b0, 1'b0, -1);
      wait_done(TMO, TMO - 1);

      // Backpressure: next frame's first sample held valid through start/send/wait; stray dones.
      new_next_frame(); take_next_frame(); new_next_frame();
      for (int f = 0; f < 6; f++) begin
         fill_frame(40, 1'b1);
         send_frame(1'b1, 1'b1, -1);
         wait_done(($urandom_range(0, 3) == 0) ? TMO : int'($urandom_range(0, TMO - 1)), -1);
         take_next_frame();
         new_next_frame();
      end

      // Reset while rd_cnt==3, then a clean frame afterwards.
      fill_frame(10, 1'b0);
      send_frame(1'b0, 1'b0, 3);
      step();
      new_next_frame(); take_next_frame(); new_next_frame();
      fill_frame(10, 1'b0);
      send_frame(1'b0, 1'b0, -1);
      wait_done(5, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
